// File: rtl/dfm_pkg.sv
// dfm_pkg
// Shared definitions for the DFM result reader.
//   - AXI4-Lite register offsets, decoded from araddr[3:2]
//   - STATUS register bit positions
//   - AXI read response codes and the constant ID word
//   - read-channel FSM state type
package dfm_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_DATA_LO = 2'd1;
  localparam logic [1:0] REG_DATA_HI = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_DROP_LSB  = 8;
  localparam int STAT_LEVEL_LSB = 16;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DFM_ID      = 32'h4446_4D31;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x 64 bits.
// The head word is visible on head_o whenever the FIFO is not empty.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write a word; ignored when full unless a pop happens too
//   pop_i        : drop the head word; ignored when empty
//   full_o/empty_o/level_o : occupancy flags and entry count
//   head_o       : oldest word
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [63:0]      data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic [63:0]      head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;

  logic w_doPop;
  logic w_doPush;

  assign full_o  = (r_level == LVL_W'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign head_o  = r_mem[r_rdPtr];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign w_doPop  = pop_i && !empty_o;
  assign w_doPush = push_i && (!full_o || w_doPop);

  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_level <= r_level + 1'b1;
      else if (w_doPop && !w_doPush) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/dfm_result_reader.sv
// dfm_result_reader
// Buffers 64-bit result words from the measure block and serves them to
// software through an AXI4-Lite read-only slave. irq_o is high while results
// are pending.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   reg_wr_en_i, reg_wr_data_i   : one-cycle result strobe and 64-bit word
//   s_axil_ar*                   : read address channel
//   s_axil_r*                    : read data channel (rdata/rresp registered)
//   irq_o                        : registered "FIFO not empty"
module dfm_result_reader
  import dfm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_wr_en_i,
  input  logic [63:0]       reg_wr_data_i,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              irq_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             w_full;
  logic             w_empty;
  logic [LVL_W-1:0] w_level;
  logic [63:0]      w_head;
  logic             w_pop;
  logic             w_clear;
  logic             w_drop;
  logic [31:0]      w_status;

  rd_state_t   r_state;
  rd_state_t   w_nextState;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] w_rdataNext;
  logic [1:0]  w_rrespNext;
  logic        r_ovf;
  logic [7:0]  r_dropCnt;
  logic        r_irq;

  result_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (reg_wr_en_i),
    .data_i  (reg_wr_data_i),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level),
    .head_o  (w_head)
  );

  // A word is lost only when the FIFO is full and nothing leaves this cycle.
  assign w_drop = reg_wr_en_i && w_full && !w_pop;

  // STATUS is built from registered state, so it is a snapshot taken before
  // any push, pop or clear happening in the same cycle.
  always_comb begin
    w_status = '0;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_DROP_LSB +: 8]  = r_dropCnt;
    w_status[STAT_LEVEL_LSB +: 8] = 8'(w_level);
  end

  // Read FSM: decode and side effects happen in the AR handshake cycle.
  always_comb begin
    w_nextState = r_state;
    w_rdataNext = r_rdata;
    w_rrespNext = r_rresp;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      RD_IDLE: begin
        if (s_axil_arvalid && r_arready) begin
          w_nextState = RD_RESP;
          w_rdataNext = '0;
          w_rrespNext = RESP_OKAY;
          if (s_axil_araddr[1:0] != 2'b00) begin
            w_rrespNext = RESP_SLVERR;
          end else begin
            unique case (s_axil_araddr[3:2])
              REG_STATUS: begin
                w_rdataNext = w_status;
                w_clear     = 1'b1;
              end
              REG_DATA_LO: begin
                if (!w_empty) w_rdataNext = w_head[31:0];
              end
              REG_DATA_HI: begin
                if (!w_empty) begin
                  w_rdataNext = w_head[63:32];
                  w_pop       = 1'b1;
                end
              end
              REG_ID: begin
                w_rdataNext = DFM_ID;
              end
            endcase
          end
        end
      end
      RD_RESP: begin
        if (s_axil_rready) w_nextState = RD_IDLE;
      end
    endcase
  end

  // arready/rvalid are registered from the next state so both stay low
  // during reset and arready rises on the first clock after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= RD_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_state   <= w_nextState;
      r_arready <= (w_nextState == RD_IDLE);
      r_rvalid  <= (w_nextState == RD_RESP);
      r_rdata   <= w_rdataNext;
      r_rresp   <= w_rrespNext;
    end
  end

  // A drop coinciding with a STATUS clear wins: the counter restarts at one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf     <= 1'b0;
      r_dropCnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (w_clear)                r_dropCnt <= 8'd1;
      else if (r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
    end else if (w_clear) begin
      r_ovf     <= 1'b0;
      r_dropCnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_irq <= 1'b0;
    else       r_irq <= !w_empty;
  end

  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign irq_o          = r_irq;

endmodule

// File: tb/tb_dfm_result_reader.sv
// tb_dfm_result_reader
// Drives result words and AXI4-Lite reads into dfm_result_reader and checks
// every response against a queue-based model of the result buffer.
module tb_dfm_result_reader;

  localparam int DEPTH = 4;
  localparam logic [31:0] ID_WORD = 32'h4446_4D31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrEn = 1'b0;
  logic [63:0] wrData = '0;
  logic [3:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        irq;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: pending words in arrival order plus the overflow record.
  logic [63:0] mQ[$];
  logic        mOvf = 1'b0;
  logic [7:0]  mDrop = '0;

  always #5 clk = ~clk;

  dfm_result_reader #(
    .DEPTH  (DEPTH),
    .ADDR_W (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .reg_wr_en_i    (wrEn),
    .reg_wr_data_i  (wrData),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .irq_o          (irq)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mQ.delete();
    mOvf  = 1'b0;
    mDrop = '0;
  endtask

  task automatic modelPush(input logic [63:0] d);
    if (mQ.size() < DEPTH) begin
      mQ.push_back(d);
    end else begin
      mOvf = 1'b1;
      if (mDrop != 8'hFF) mDrop = mDrop + 8'd1;
    end
  endtask

  // Read side effects are applied before a same-cycle push.
  task automatic modelRead(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    if (a[1:0] != 2'b00) begin
      r = 2'b10;
    end else begin
      case (a[3:2])
        2'd0: begin
          d = {8'h00, 8'(mQ.size()), mDrop, 5'b0, mOvf,
               (mQ.size() == DEPTH), (mQ.size() == 0)};
          mOvf  = 1'b0;
          mDrop = '0;
        end
        2'd1: if (mQ.size() != 0) d = mQ[0][31:0];
        2'd2: if (mQ.size() != 0) begin
          d = mQ[0][63:32];
          void'(mQ.pop_front());
        end
        default: d = ID_WORD;
      endcase
    end
  endtask

  task automatic applyPush(input logic [63:0] d);
    @(negedge clk);
    wrEn   = 1'b1;
    wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
    modelPush(d);
  endtask

  // One complete AXI read; optionally pulses a result word in the AR handshake cycle.
  task automatic applyRead(input logic [3:0] a, input logic doPush, input logic [63:0] pd,
                           output logic [31:0] d, output logic [1:0] r);
    int waitCnt;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    waitCnt = 0;
    while (!arready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!arready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ar_timeout: arready=%0b after %0d cycles, required 1", arready, waitCnt);
      arvalid = 1'b0;
      d = 'x;
      r = 'x;
      return;
    end
    if (doPush) begin
      wrEn   = 1'b1;
      wrData = pd;
    end
    @(negedge clk);
    arvalid = 1'b0;
    wrEn    = 1'b0;
    waitCnt = 0;
    while (!rvalid && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rvalid) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL r_timeout: rvalid=%0b after %0d cycles, required 1", rvalid, waitCnt);
      d = 'x;
      r = 'x;
      return;
    end
    d = rdata;
    r = rresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if (arready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_arready: got %0b want 0", arready); end
    testsRun++;
    if (rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rvalid: got %0b want 0", rvalid); end
    testsRun++;
    if (rdata !== 32'h0 || rresp !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL reset_rdata: got %h/%b want 0/00", rdata, rresp);
    end
    testsRun++;
    if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq: got %0b want 0", irq); end
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    testsRun++;
    if (arready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_arready: got %0b want 1", arready); end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, d, r);
    testsRun++;
    if (d !== 32'h0000_0001 || r !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL reset_status: got %h/%b want 00000001/00", d, r);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] d, e;
    logic [1:0]  r, er;
    applyPush(64'h0000_0003_0000_00C8);
    @(negedge clk);
    testsRun++;
    if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_irq: got %0b want 1", irq); end
    applyRead(4'h4, 1'b0, '0, d, r);
    modelRead(4'h4, e, er);
    testsRun++;
    if (d !== 32'h0000_00C8 || r !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL single_lo: got %h want 000000c8", d);
    end
    applyRead(4'h8, 1'b0, '0, d, r);
    modelRead(4'h8, e, er);
    testsRun++;
    if (d !== 32'h0000_0003 || r !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL single_hi: got %h want 00000003", d);
    end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0000_0001) begin testsFailed++; $display("[TB] FAIL single_status: got %h want 00000001", d); end
    @(negedge clk);
    testsRun++;
    if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_irq_clear: got %0b want 0", irq); end
  endtask

  task automatic test_overflow();
    logic [63:0] words [5];
    logic [31:0] d, e;
    logic [1:0]  r, er;
    for (int i = 0; i < 5; i++) begin
      words[i] = {$urandom, $urandom};
      applyPush(words[i]);
    end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0004_0106) begin testsFailed++; $display("[TB] FAIL ovf_status1: got %h want 00040106", d); end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0004_0002) begin testsFailed++; $display("[TB] FAIL ovf_status2: got %h want 00040002", d); end
    for (int i = 0; i < 4; i++) begin
      applyRead(4'h8, 1'b0, '0, d, r);
      modelRead(4'h8, e, er);
      testsRun++;
      if (d !== words[i][63:32]) begin
        testsFailed++; $display("[TB] FAIL ovf_drain%0d: got %h want %h", i, d, words[i][63:32]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w0, w1;
    logic [31:0] e;
    logic [1:0]  er;
    int waitCnt;
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    applyPush(w0);
    @(negedge clk);
    araddr  = 4'h8;
    arvalid = 1'b1;
    rready  = 1'b0;
    waitCnt = 0;
    while (!arready && waitCnt < 20) begin @(negedge clk); waitCnt++; end
    @(negedge clk);
    modelRead(4'h8, e, er);
    araddr = 4'h0;
    wrEn   = 1'b1;
    wrData = w1;
    for (int i = 0; i < 10; i++) begin
      testsRun++;
      if (rvalid !== 1'b1 || rdata !== w0[63:32] || arready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: rvalid=%0b rdata=%h arready=%0b want 1/%h/0",
                 i, rvalid, rdata, arready, w0[63:32]);
      end
      @(negedge clk);
      if (i == 0) begin
        wrEn = 1'b0;
        modelPush(w1);
      end
    end
    rready = 1'b1;
    @(negedge clk);
    testsRun++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL hold_retire: rvalid=%0b arready=%0b want 0/1", rvalid, arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    modelRead(4'h0, e, er);
    testsRun++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      testsFailed++; $display("[TB] FAIL hold_second: rvalid=%0b rdata=%h want 1/%h", rvalid, rdata, e);
    end
    @(negedge clk);
  endtask

  task automatic test_push_pop_full();
    logic [63:0] newW;
    logic [31:0] d, e;
    logic [1:0]  r, er;
    while (mQ.size() < DEPTH) applyPush({$urandom, $urandom});
    newW = {$urandom, $urandom};
    applyRead(4'h8, 1'b1, newW, d, r);
    modelRead(4'h8, e, er);
    modelPush(newW);
    testsRun++;
    if (d !== e) begin testsFailed++; $display("[TB] FAIL full_pop_data: got %h want %h", d, e); end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0004_0002) begin testsFailed++; $display("[TB] FAIL full_pop_status: got %h want 00040002", d); end
    for (int i = 0; i < 4; i++) begin
      applyRead(4'h4, 1'b0, '0, d, r);
      modelRead(4'h4, e, er);
      testsRun++;
      if (d !== e) begin testsFailed++; $display("[TB] FAIL full_drain_lo%0d: got %h want %h", i, d, e); end
      applyRead(4'h8, 1'b0, '0, d, r);
      modelRead(4'h8, e, er);
      testsRun++;
      if (d !== e) begin testsFailed++; $display("[TB] FAIL full_drain_hi%0d: got %h want %h", i, d, e); end
    end
    testsRun++;
    if (d !== newW[63:32]) begin testsFailed++; $display("[TB] FAIL full_new_last: got %h want %h", d, newW[63:32]); end
  endtask

  task automatic test_errors_and_reset();
    logic [31:0] d, e;
    logic [1:0]  r, er;
    int waitCnt;
    applyPush({$urandom, $urandom});
    applyRead(4'h1, 1'b0, '0, d, r);
    modelRead(4'h1, e, er);
    testsRun++;
    if (r !== 2'b10 || d !== 32'h0) begin testsFailed++; $display("[TB] FAIL slverr: got %h/%b want 0/10", d, r); end
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0001_0000) begin testsFailed++; $display("[TB] FAIL slverr_nopop: got %h want 00010000", d); end
    applyRead(4'hC, 1'b0, '0, d, r);
    modelRead(4'hC, e, er);
    testsRun++;
    if (d !== ID_WORD || r !== 2'b00) begin testsFailed++; $display("[TB] FAIL id: got %h/%b want %h/00", d, r, ID_WORD); end
    @(negedge clk);
    araddr  = 4'h4;
    arvalid = 1'b1;
    rready  = 1'b0;
    waitCnt = 0;
    while (!arready && waitCnt < 20) begin @(negedge clk); waitCnt++; end
    @(negedge clk);
    arvalid = 1'b0;
    testsRun++;
    if (rvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_pre: rvalid=%0b want 1", rvalid); end
    rst = 1'b1;
    @(negedge clk);
    testsRun++;
    if (rvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_rvalid: rvalid=%0b want 0", rvalid); end
    rst    = 1'b0;
    rready = 1'b1;
    modelReset();
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0000_0001) begin testsFailed++; $display("[TB] FAIL midrst_status: got %h want 00000001", d); end
  endtask

  task automatic test_saturate();
    logic [31:0] d, e;
    logic [1:0]  r, er;
    for (int i = 0; i < DEPTH + 260; i++) applyPush({$urandom, $urandom});
    applyRead(4'h0, 1'b0, '0, d, r);
    modelRead(4'h0, e, er);
    testsRun++;
    if (d !== 32'h0004_FF06) begin testsFailed++; $display("[TB] FAIL saturate: got %h want 0004ff06", d); end
  endtask

  task automatic test_random();
    logic [3:0]  addrTable [8] = '{4'h0, 4'h4, 4'h8, 4'h8, 4'hC, 4'h1, 4'h4, 4'h8};
    logic [31:0] d, e;
    logic [1:0]  r, er;
    logic [63:0] w;
    logic        withPush;
    logic [3:0]  a;
    for (int i = 0; i < 200; i++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        applyPush(w);
      end else begin
        a = addrTable[$urandom_range(0, 7)];
        withPush = ($urandom_range(0, 3) == 0);
        applyRead(a, withPush, w, d, r);
        modelRead(a, e, er);
        if (withPush) modelPush(w);
        testsRun++;
        if (d !== e || r !== er) begin
          testsFailed++;
          $display("[TB] FAIL random%0d addr %h: got %h/%b want %h/%b", i, a, d, r, e, er);
        end
      end
      @(negedge clk);
      testsRun++;
      if (irq !== (mQ.size() != 0)) begin
        testsFailed++; $display("[TB] FAIL random_irq%0d: got %0b want %0b", i, irq, mQ.size() != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_backpressure();
    test_push_pop_full();
    test_errors_and_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
